// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (C) has priority, DMA (D) gets anti-starvation grants
// and may lock the port for bounded bursts. Single-cycle accesses, registered read return.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LOCK     = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [2:0]            c_funct3,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_lock,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(MAX_LOCK);
    // A one-grant lock would expire on its own entry grant, so it never enters StDlock.
    localparam bit LOCK_ALLOWED = (MAX_LOCK > 1);

    typedef enum logic {StArb, StDlock} state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  c_rvalid_q, c_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state_q == StDlock) begin
                d_gnt = d_req;
            end else begin
                d_gnt = d_req && (!c_req || (starve_cnt_q == STARVE_MAX));
                c_gnt = c_req && !d_gnt;
            end
        end
    end

    // Idle cycles steer port C onto the bus so the memory never sees X.
    always_comb begin
        mem_wr_en   = d_gnt ? d_we : (c_gnt & c_we);
        mem_funct3  = d_gnt ? d_funct3 : c_funct3;
        mem_addr    = d_gnt ? d_addr : c_addr;
        mem_wr_data = d_gnt ? d_wdata : c_wdata;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (d_gnt || !d_req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            StArb: begin
                if (d_gnt && d_lock && LOCK_ALLOWED) begin
                    state_d    = StDlock;
                    lock_cnt_d = LW'(1);
                end
            end
            StDlock: begin
                if (!d_lock || !d_req || (lock_cnt_q + LW'(1) == LOCK_MAX)) begin
                    state_d    = StArb;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d    = StArb;
                lock_cnt_d = '0;
            end
        endcase

        c_rvalid_d = c_gnt & ~c_we;
        d_rvalid_d = d_gnt & ~d_we;
        c_rdata_d  = c_rvalid_d ? mem_rd_data : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? mem_rd_data : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StArb;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core load/store path (port C) and a DMA/debug loader (port D).
- Each access is a single cycle. The grant is combinational and issued in the request cycle; writes commit at the memory's next clk edge.
- Read data is registered and returned one cycle after the grant.
- Core has priority by default. A wait counter forces a D grant so D cannot starve, and D may lock the port for short bursts.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, number of consecutive cycles D may be denied before it is forced a grant (must be >= 1)
- MAX_LOCK, 8, maximum number of consecutive D grants while d_lock is held (must be >= 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- c_req  in  1  core access request
- c_we  in  1  core write enable
- c_funct3  in  3  core access size/sign, RISC-V load/store encoding
- c_addr  in  ADDR_WIDTH  core byte address
- c_wdata  in  DATA_WIDTH  core store data
- c_gnt  out  1  core granted this cycle (combinational)
- c_rvalid  out  1  core read data valid (registered)
- c_rdata  out  DATA_WIDTH  core read data (registered)
- d_req, d_we, d_funct3, d_addr, d_wdata  in  same widths as port C  DMA request
- d_lock  in  1  DMA requests back-to-back ownership of the port
- d_gnt, d_rvalid, d_rdata  out  same as port C  DMA responses
- mem_wr_en  out  1  to memory write enable
- mem_funct3  out  3  to memory
- mem_addr  out  ADDR_WIDTH  to memory
- mem_wr_data  out  DATA_WIDTH  to memory
- mem_rd_data  in  DATA_WIDTH  combinational read data from memory

Behaviour:
- State:
  - 2-state FSM: ARB (normal) and DLOCK (D owns the port).
  - starve_cnt: counts consecutive D-denied cycles, clog2(STARVE_LIMIT+1) bits.
  - lock_cnt: counts D grants within the current lock.
  - Registered response flags and data for each port.
- Reset:
  - FSM returns to ARB; starve_cnt=0, lock_cnt=0.
  - c_rvalid=0, d_rvalid=0, c_rdata=0, d_rdata=0.
  - A reset mid-lock drops the lock immediately. No write is issued in a cycle where reset is high: gnt=0 and mem_wr_en=0 while reset=1.
- ARB grant rule, evaluated each cycle:
  - D is granted if d_req and (!c_req or starve_cnt==STARVE_LIMIT).
  - Otherwise C is granted if c_req.
  - Otherwise neither is granted.
- DLOCK grant rule:
  - D is granted if d_req.
  - C is never granted, even if c_req is high.
- At most one gnt is high per cycle; c_gnt and d_gnt are mutually exclusive.
- Memory mux:
  - mem_addr, mem_funct3 and mem_wr_data come from the granted port.
  - mem_wr_en = granted port's we.
  - With no grant: mem_wr_en=0, and mem_addr/funct3/wr_data come from port C (don't-care for verification, but must not be X).
- starve_cnt:
  - Resets to 0 on any D grant or when d_req is low.
  - Increments, saturating at STARVE_LIMIT, when d_req is high and d_gnt is low.
- DLOCK entry and exit:
  - ARB -> DLOCK on the edge after a D grant with d_lock=1; lock_cnt is then 1.
  - In DLOCK, each D grant increments lock_cnt.
  - DLOCK -> ARB on the edge where d_lock=0, or d_req=0, or a grant brings lock_cnt to MAX_LOCK.
  - On exit, lock_cnt=0 and starve_cnt=0.
  - If c_req is pending on the exit edge, C wins the next cycle unless starvation applies.
- Read response:
  - On the edge after a granted read (we=0), the granted port's rvalid=1 and its rdata = mem_rd_data sampled in the grant cycle.
  - The other port's rvalid=0.
  - rvalid is a 1-cycle pulse per granted read. Writes produce no rvalid.
  - rdata holds its value until the next read for that port.
- Throughput: 1 access/cycle; no bubbles between consecutive grants.
- Requesters must hold req and their fields stable until gnt. The arbiter does not queue requests.

Test Plan:
- Core only: c_req read at addr 0x8 (funct3=010) with the memory word = 0xDEADBEEF -> c_gnt=1 in the same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; d_* outputs remain 0.
- Contention/starvation: c_req and d_req held high continuously with STARVE_LIMIT=4 -> C granted 4 cycles, D granted on the 5th; pattern repeats (C,C,C,C,D).
- D write: d_req/d_we with funct3=000, addr=0x13, data=0xA5 -> d_gnt=1, mem_wr_en=1, mem_addr=0x13, mem_funct3=000; no d_rvalid afterwards.
- Lock burst: D granted with d_lock=1, MAX_LOCK=8, c_req also high -> D granted 8 consecutive cycles with c_gnt=0 throughout; C granted on the 9th cycle.
- Lock early release: d_lock dropped after 3 D grants while c_req is high -> FSM returns to ARB; next cycle c_gnt=1.
- Reset mid-lock: reset asserted in the 3rd lock cycle -> same cycle gnt=0 and mem_wr_en=0; after reset both rvalid=0, FSM in ARB, and a c_req is granted immediately.
